button_scheduler: RTL and testbench

- Sits between the raw keypad inputs and the calculator controller.
- Debounces each button line and turns each debounced rising edge into a one-hot-free button code.
- Queues press events in a small FIFO and hands them to the controller over a valid/ready handshake, so the controller only consumes a press when it is back in its idle state.
- ON is a priority button: it flushes the queue.

---
 rtl/button_scheduler.sv | 139 +++++++++++++
 tb/tb_button_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/button_scheduler.sv
// button_scheduler: per-line debounce, rising-edge press detection, and a small
// press FIFO handed to the calculator controller over valid/ready. An ON press
// has priority and flushes the queue.
module button_scheduler #(
  parameter int NumButtons     = 23,
  parameter int DebounceCycles = 4,
  parameter int QueueDepth     = 4,
  parameter int OnIndex        = 0,
  parameter int CodeW          = $clog2(NumButtons + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumButtons-1:0]            buttons_i,
  output logic [CodeW-1:0]                 press_o,
  output logic                             press_valid_o,
  input  logic                             press_ready_i,
  output logic                             drop_o,
  output logic [$clog2(QueueDepth+1)-1:0]  count_o
);

  localparam int CntW = $clog2(QueueDepth + 1);
  localparam int PtrW = $clog2(QueueDepth);
  localparam int DbW  = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [DbW-1:0]  DbLast = DbW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(QueueDepth);

  logic [NumButtons-1:0] r_deb;
  logic [DbW-1:0]        r_dbcnt [NumButtons];
  logic [NumButtons-1:0] w_flip;
  logic [NumButtons-1:0] w_rise;

  logic [CodeW-1:0]      w_sel_idx;
  logic [CodeW-1:0]      w_code;
  logic                  w_found;
  logic                  w_on;
  logic                  w_any;
  logic                  w_multi;

  logic [CodeW-1:0]      r_mem [QueueDepth];
  logic [PtrW-1:0]       r_head;
  logic [PtrW-1:0]       r_tail;
  logic [CntW-1:0]       r_count;
  logic                  r_drop;

  logic                  w_valid;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;

  // Flip condition per line; a rise is a flip while the debounced level is low.
  always_comb begin
    w_flip = '0;
    for (int unsigned i = 0; i < NumButtons; i++) begin
      w_flip[i] = (buttons_i[i] != r_deb[i]) && (r_dbcnt[i] == DbLast);
    end
    w_rise = w_flip & ~r_deb;
  end

  // Debounce counters: count consecutive disagreeing cycles, flip on the last one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_deb <= '0;
      for (int unsigned i = 0; i < NumButtons; i++) r_dbcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NumButtons; i++) begin
        if (buttons_i[i] == r_deb[i]) begin
          r_dbcnt[i] <= '0;
        end else if (r_dbcnt[i] == DbLast) begin
          r_deb[i]   <= ~r_deb[i];
          r_dbcnt[i] <= '0;
        end else begin
          r_dbcnt[i] <= r_dbcnt[i] + 1'b1;
        end
      end
    end
  end

  // Pick one rising line (ON first, else lowest index); any extra rises are dropped.
  always_comb begin
    w_found   = 1'b0;
    w_sel_idx = '0;
    for (int unsigned i = 0; i < NumButtons; i++) begin
      if (!w_found && w_rise[i]) begin
        w_found   = 1'b1;
        w_sel_idx = CodeW'(i);
      end
    end
    w_on = w_rise[OnIndex];
    if (w_on) w_sel_idx = CodeW'(OnIndex);
    w_code  = w_sel_idx + CodeW'(1);
    w_any   = |w_rise;
    // More than one bit set means at least one press is discarded.
    w_multi = (w_rise & (w_rise - 1'b1)) != '0;
  end

  // Queue control: push/pop decisions and this-cycle drop condition.
  always_comb begin
    w_valid = (r_count != '0);
    w_full  = (r_count == CntFull);
    w_pop   = w_valid && press_ready_i;
    w_push  = w_any && !w_on && (!w_full || w_pop);
    w_drop  = w_multi || (w_any && !w_on && w_full && !w_pop);
  end

  // Pointers, occupancy and registered drop pulse; ON flush overrides everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_drop;
      if (w_on) begin
        r_head  <= '0;
        r_tail  <= PtrW'(1);
        r_count <= CntW'(1);
      end else begin
        if (w_push) r_tail <= r_tail + 1'b1;
        if (w_pop)  r_head <= r_head + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage array; contents are only observed through the occupancy-gated head.
  always_ff @(posedge clk_i) begin
    if (w_on)        r_mem[0]      <= w_code;
    else if (w_push) r_mem[r_tail] <= w_code;
  end

  assign press_valid_o = w_valid;
  assign press_o       = w_valid ? r_mem[r_head] : '0;
  assign drop_o        = r_drop;
  assign count_o       = r_count;

endmodule

// File: tb/tb_button_scheduler.sv
// Directed bench for button_scheduler with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_button_scheduler;

  localparam int NB = 23;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] buttons = '0;
  logic          ready = 1'b0;
  logic [4:0]    press;
  logic          valid;
  logic          drop;
  logic [2:0]    count;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned n_drops = 0;

  button_scheduler #(
    .NumButtons    (NB),
    .DebounceCycles(4),
    .QueueDepth    (4),
    .OnIndex       (0)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .buttons_i    (buttons),
    .press_o      (press),
    .press_valid_o(valid),
    .press_ready_i(ready),
    .drop_o       (drop),
    .count_o      (count)
  );

  always #5 clk = ~clk;

  // Count drop pulses seen at each sampling point.
  always @(negedge clk) if (!rst && drop) n_drops++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    buttons = '0;
    ready = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    n_drops = 0;
  endtask

  // Hold one line high through its flip edge, then release it.
  task automatic press_bit(input int b);
    buttons[b] = 1'b1;
    cyc(4);
    buttons[b] = 1'b0;
  endtask

  logic [3:0] bounce;
  logic [8:0] bvec;

  initial begin
    // Reset state
    cyc(1);
    chk("rst_valid", valid, 0);
    chk("rst_press", press, 0);
    chk("rst_count", count, 0);
    chk("rst_drop",  drop,  0);
    do_reset();

    // Clean press of bit 5: flip on the 4th rising edge, valid seen right after
    buttons[5] = 1'b1;
    cyc(3);
    chk("clean_valid_early", valid, 0);
    cyc(1);
    chk("clean_valid", valid, 1);
    chk("clean_press", press, 6);
    chk("clean_count", count, 1);
    cyc(6);
    buttons[5] = 1'b0;
    cyc(8);
    chk("clean_release_count", count, 1);
    chk("clean_release_press", press, 6);
    chk("clean_drops", n_drops, 0);

    // Bounce rejection on bit 3: only the final 4-long stable run counts
    do_reset();
    bvec = 9'b111101101; // applied LSB first: 1,0,1,1,0,1,1,1,1
    for (int k = 0; k < 9; k++) begin
      buttons[3] = bvec[k];
      cyc(1);
      if (k == 7) chk("bounce_not_yet", valid, 0);
    end
    chk("bounce_valid", valid, 1);
    chk("bounce_press", press, 4);
    buttons[3] = 1'b0;
    cyc(6);
    chk("bounce_count", count, 1);
    chk("bounce_drops", n_drops, 0);

    // Ordering and pop
    do_reset();
    press_bit(1); cyc(4);
    press_bit(2); cyc(4);
    press_bit(3); cyc(4);
    chk("order_count", count, 3);
    ready = 1'b1;
    chk("order_head0", press, 2);
    cyc(1);
    chk("order_head1", press, 3);
    chk("order_count1", count, 2);
    cyc(1);
    chk("order_head2", press, 4);
    cyc(1);
    chk("order_valid_end", valid, 0);
    chk("order_count_end", count, 0);
    chk("order_press_end", press, 0);
    ready = 1'b0;

    // Overflow: fifth press dropped
    do_reset();
    for (int b = 1; b <= 4; b++) press_bit(b);
    chk("ovf_count4", count, 4);
    chk("ovf_nodrop", n_drops, 0);
    press_bit(5);
    chk("ovf_drop_pulse", drop, 1);
    chk("ovf_count", count, 4);
    chk("ovf_head", press, 2);
    cyc(1);
    chk("ovf_drop_end", drop, 0);
    cyc(4);
    chk("ovf_drops", n_drops, 1);

    // Full with simultaneous pop: bit 8 flips on the same edge as a pop
    n_drops = 0;
    buttons[8] = 1'b1;
    cyc(3);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    buttons[8] = 1'b0;
    chk("fullpop_count", count, 4);
    chk("fullpop_head", press, 3);
    chk("fullpop_drop", drop, 0);
    ready = 1'b1;
    chk("drain0", press, 3);
    cyc(1); chk("drain1", press, 4);
    cyc(1); chk("drain2", press, 5);
    cyc(1); chk("drain3", press, 9);
    cyc(1); chk("drain_empty", valid, 0);
    ready = 1'b0;
    chk("fullpop_drops", n_drops, 0);

    // ON flush with a simultaneous bit-7 rise
    do_reset();
    press_bit(1);
    press_bit(2);
    press_bit(3);
    chk("on_pre_count", count, 3);
    buttons[0] = 1'b1;
    buttons[7] = 1'b1;
    cyc(4);
    chk("on_count", count, 1);
    chk("on_press", press, 1);
    chk("on_drop", drop, 1);
    cyc(1);
    chk("on_drop_end", drop, 0);
    chk("on_drops", n_drops, 1);

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_press", press, 0);
    chk("arst_count", count, 0);
    chk("arst_drop",  drop,  0);
    cyc(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
